// File: rtl/usb_rx_packet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_packet_ctrl
// Purpose  : Packet-level receive sequencer behind the JK decoder. Frames
//            the decoded bit stream, checks SYNC/PID, assembles payload bytes.
// Revision : 1.0 - initial release
// ============================================================================
module usb_rx_packet_ctrl #(
  parameter int IDLE_TIMEOUT = 8,
  parameter int MAX_BYTES    = 1025
) (
  input  logic       clk36,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       bus_sop,
  input  logic       bus_reset,
  output logic [3:0] pid_out,
  output logic       pid_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       pkt_end,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       usb_reset_evt,
  output logic       busy
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_SYNC  = 3'd1;
  localparam logic [2:0] c_PID   = 3'd2;
  localparam logic [2:0] c_DATA  = 3'd3;
  localparam logic [2:0] c_DRAIN = 3'd4;

  localparam logic [1:0] c_ERR_SYNC  = 2'd0;
  localparam logic [1:0] c_ERR_PID   = 2'd1;
  localparam logic [1:0] c_ERR_ABORT = 2'd2;
  localparam logic [1:0] c_ERR_OVFL  = 2'd3;

  localparam int c_TO_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int c_BC_W = $clog2(MAX_BYTES + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(IDLE_TIMEOUT - 1);
  localparam logic [c_TO_W-1:0] c_TO_ONE   = c_TO_W'(1);
  localparam logic [c_BC_W-1:0] c_BYTE_MAX = c_BC_W'(MAX_BYTES);
  localparam logic [c_BC_W-1:0] c_BC_ONE   = c_BC_W'(1);

  logic [2:0]        r_state;
  logic [7:0]        r_shreg;
  logic [2:0]        r_bit_cnt;
  logic [c_BC_W-1:0] r_byte_cnt;
  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_bus_reset_d;

  logic [3:0] r_pid_out;
  logic       r_pid_valid;
  logic [7:0] r_byte_out;
  logic       r_byte_valid;
  logic       r_pkt_end;
  logic       r_pkt_err;
  logic [1:0] r_err_code;
  logic       r_usb_reset_evt;

  logic [7:0] w_byte;
  logic       w_byte_done;
  logic       w_to_hit;
  logic       w_in_pkt;

  // LSB-first: each new bit enters at the top and walks down to bit 0.
  assign w_byte      = {bit_in, r_shreg[7:1]};
  assign w_byte_done = (r_bit_cnt == 3'd7);
  assign w_to_hit    = (r_to_cnt == c_TO_LAST);
  assign w_in_pkt    = (r_state == c_SYNC) || (r_state == c_PID) || (r_state == c_DATA);

  always_ff @(posedge clk36) begin
    if (reset) begin
      r_state         <= c_IDLE;
      r_shreg         <= 8'd0;
      r_bit_cnt       <= 3'd0;
      r_byte_cnt      <= '0;
      r_to_cnt        <= '0;
      r_bus_reset_d   <= 1'b0;
      r_pid_out       <= 4'd0;
      r_pid_valid     <= 1'b0;
      r_byte_out      <= 8'd0;
      r_byte_valid    <= 1'b0;
      r_pkt_end       <= 1'b0;
      r_pkt_err       <= 1'b0;
      r_err_code      <= 2'd0;
      r_usb_reset_evt <= 1'b0;
    end else begin
      r_pid_valid     <= 1'b0;
      r_byte_valid    <= 1'b0;
      r_pkt_end       <= 1'b0;
      r_pkt_err       <= 1'b0;
      r_usb_reset_evt <= 1'b0;
      r_bus_reset_d   <= bus_reset;

      if (bus_reset) begin
        r_state    <= c_IDLE;
        r_shreg    <= 8'd0;
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= '0;
        r_to_cnt   <= '0;
        if (!r_bus_reset_d) begin
          r_usb_reset_evt <= 1'b1;
          if (w_in_pkt) begin
            r_pkt_end  <= 1'b1;
            r_pkt_err  <= 1'b1;
            r_err_code <= c_ERR_ABORT;
          end
        end
      end else if (bus_sop) begin
        // A new SOP aborts whatever was in flight; DRAIN already reported.
        if (w_in_pkt) begin
          r_pkt_end  <= 1'b1;
          r_pkt_err  <= 1'b1;
          r_err_code <= c_ERR_ABORT;
        end
        r_state    <= c_SYNC;
        r_shreg    <= 8'd0;
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= '0;
        r_to_cnt   <= '0;
      end else if (r_state != c_IDLE) begin
        if (bit_valid) begin
          r_to_cnt <= '0;
          if (r_state != c_DRAIN) begin
            r_shreg   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
              case (r_state)
                c_SYNC: begin
                  if (w_byte == 8'h80) begin
                    r_state <= c_PID;
                  end else begin
                    r_pkt_end  <= 1'b1;
                    r_pkt_err  <= 1'b1;
                    r_err_code <= c_ERR_SYNC;
                    r_state    <= c_DRAIN;
                  end
                end
                c_PID: begin
                  if (w_byte[7:4] == ~w_byte[3:0]) begin
                    r_pid_out   <= w_byte[3:0];
                    r_pid_valid <= 1'b1;
                    r_state     <= c_DATA;
                  end else begin
                    r_pkt_end  <= 1'b1;
                    r_pkt_err  <= 1'b1;
                    r_err_code <= c_ERR_PID;
                    r_state    <= c_DRAIN;
                  end
                end
                c_DATA: begin
                  if (r_byte_cnt == c_BYTE_MAX) begin
                    r_pkt_end  <= 1'b1;
                    r_pkt_err  <= 1'b1;
                    r_err_code <= c_ERR_OVFL;
                    r_state    <= c_DRAIN;
                  end else begin
                    r_byte_out   <= w_byte;
                    r_byte_valid <= 1'b1;
                    r_byte_cnt   <= r_byte_cnt + c_BC_ONE;
                  end
                end
                default: r_state <= c_DRAIN;
              endcase
            end
          end
        end else if (w_to_hit) begin
          r_state    <= c_IDLE;
          r_to_cnt   <= '0;
          r_bit_cnt  <= 3'd0;
          r_byte_cnt <= '0;
          if ((r_state == c_DATA) && (r_bit_cnt == 3'd0)) begin
            r_pkt_end <= 1'b1;
          end else if (r_state != c_DRAIN) begin
            r_pkt_end  <= 1'b1;
            r_pkt_err  <= 1'b1;
            r_err_code <= c_ERR_ABORT;
          end
        end else begin
          r_to_cnt <= r_to_cnt + c_TO_ONE;
        end
      end
    end
  end

  assign pid_out       = r_pid_out;
  assign pid_valid     = r_pid_valid;
  assign byte_out      = r_byte_out;
  assign byte_valid    = r_byte_valid;
  assign pkt_end       = r_pkt_end;
  assign pkt_err       = r_pkt_err;
  assign err_code      = r_err_code;
  assign usb_reset_evt = r_usb_reset_evt;
  assign busy          = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_packet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_packet_ctrl
// Purpose  : Directed self-checking bench for usb_rx_packet_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx_packet_ctrl;

  logic       clk36 = 1'b0;
  logic       reset = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bus_sop = 1'b0;
  logic       bus_reset = 1'b0;
  logic [3:0] pid_out;
  logic       pid_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       pkt_end;
  logic       pkt_err;
  logic [1:0] err_code;
  logic       usb_reset_evt;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int         n_pid, n_byte, n_end, n_evt;
  logic [3:0] last_pid;
  logic       last_err;
  logic [1:0] last_code;
  logic [7:0] byte_q[$];

  usb_rx_packet_ctrl dut (
    .clk36(clk36), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bus_sop(bus_sop), .bus_reset(bus_reset), .pid_out(pid_out),
    .pid_valid(pid_valid), .byte_out(byte_out), .byte_valid(byte_valid),
    .pkt_end(pkt_end), .pkt_err(pkt_err), .err_code(err_code),
    .usb_reset_evt(usb_reset_evt), .busy(busy)
  );

  always #5 clk36 = ~clk36;

  always @(negedge clk36) begin
    if (pid_valid) begin n_pid++; last_pid = pid_out; end
    if (byte_valid) begin n_byte++; byte_q.push_back(byte_out); end
    if (pkt_end) begin n_end++; last_err = pkt_err; last_code = err_code; end
    if (usb_reset_evt) n_evt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk36);
    #1;
  endtask

  task automatic clr();
    n_pid = 0; n_byte = 0; n_end = 0; n_evt = 0;
    last_pid = 4'd0; last_err = 1'b0; last_code = 2'd0;
    byte_q.delete();
  endtask

  task automatic sop();
    bus_sop = 1'b1;
    tick();
    bus_sop = 1'b0;
  endtask

  // One bit every 3 cycles: valid for one cycle, then two idle cycles.
  task automatic send_bit(input logic b);
    bit_in = b; bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  initial begin
    logic [7:0] v;
    int bad;
    clr();
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_outs", {pid_out, pid_valid, byte_out, byte_valid, pkt_end, pkt_err,
                       err_code, usb_reset_evt}, 0);
    reset = 1'b0;
    tick();

    // Normal DATA packet with two bytes, exact timeout position
    clr();
    sop();
    send_byte(8'h80); send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
    repeat (5) tick();
    check("t1_busy_before_to", busy, 1);
    check("t1_no_end_yet", n_end, 0);
    tick();
    check("t1_end_pulse", {pkt_end, pkt_err}, 2'b10);
    check("t1_busy_after", busy, 0);
    repeat (10) tick();
    check("t1_npid", n_pid, 1);
    check("t1_pid", last_pid, 4'h5);
    check("t1_nbyte", n_byte, 2);
    check("t1_bytes", {byte_q[0], byte_q[1]}, 16'h1234);
    check("t1_nend", n_end, 1);

    // Bad SYNC 0x81
    clr();
    sop();
    v = 8'h81;
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    bit_in = v[7]; bit_valid = 1'b1;
    tick();
    check("t2_sync_err", {pkt_end, pkt_err, err_code}, 4'b1100);
    bit_valid = 1'b0;
    tick(); tick();
    send_byte(8'hA5);
    repeat (20) tick();
    check("t2_npid", n_pid, 0);
    check("t2_nend", n_end, 1);
    check("t2_busy", busy, 0);

    // Handshake ACK, zero bytes
    clr();
    sop(); send_byte(8'h80); send_byte(8'hD2);
    repeat (20) tick();
    check("t3_ack", {n_pid[3:0], last_pid, n_byte[3:0], n_end[3:0], 3'(last_err)}, {4'd1, 4'h2, 4'd0, 4'd1, 3'd0});

    // PID check failure
    clr();
    sop(); send_byte(8'h80); send_byte(8'hD3);
    repeat (20) tick();
    check("t3_pid_bad", {n_pid[3:0], n_end[3:0], 3'(last_err), 2'(last_code)}, {4'd0, 4'd1, 3'd1, 2'd1});

    // Partial byte then idle -> alignment abort
    clr();
    sop(); send_byte(8'h80); send_byte(8'hC3); send_byte(8'h11);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (20) tick();
    check("t4_nbyte", n_byte, 1);
    check("t4_byte", byte_q[0], 8'h11);
    check("t4_end", {n_end[3:0], 3'(last_err), 2'(last_code)}, {4'd1, 3'd1, 2'd2});

    // Overflow: 1026 bytes plus one more after the error
    clr();
    sop(); send_byte(8'h80); send_byte(8'hC3);
    for (int i = 0; i < 1026; i++) send_byte(8'((i * 7) + 3));
    check("t5_ovfl_end", {n_end[3:0], 3'(last_err), 2'(last_code)}, {4'd1, 3'd1, 2'd3});
    send_byte(8'hEE);
    repeat (20) tick();
    check("t5_nbyte", n_byte, 1025);
    bad = 0;
    for (int i = 0; i < byte_q.size(); i++)
      if (byte_q[i] !== 8'((i * 7) + 3)) bad++;
    check("t5_byte_vals", bad, 0);
    check("t5_nend", n_end, 1);

    // bus_reset mid-DATA
    clr();
    sop(); send_byte(8'h80); send_byte(8'hC3); send_byte(8'h55);
    send_bit(1'b1); send_bit(1'b1);
    bus_reset = 1'b1;
    tick();
    check("t6_evt_end", {usb_reset_evt, pkt_end, pkt_err, err_code}, 5'b11110);
    for (int i = 0; i < 100; i++) begin
      bus_sop = (i == 10);
      bit_valid = (i % 3 == 0);
      tick();
    end
    bus_sop = 1'b0; bit_valid = 1'b0; bus_reset = 1'b0;
    check("t6_busy_held", busy, 0);
    check("t6_once", {n_evt[7:0], n_end[7:0]}, 16'h0101);
    repeat (3) tick();
    clr();
    sop(); send_byte(8'h80); send_byte(8'hA5); send_byte(8'h77);
    repeat (20) tick();
    check("t6_after", {n_pid[3:0], last_pid, n_byte[3:0], n_end[3:0], 3'(last_err)}, {4'd1, 4'h5, 4'd1, 4'd1, 3'd0});
    check("t6_after_byte", byte_q[0], 8'h77);

    // Reset mid-packet: silent return to idle
    clr();
    sop(); send_byte(8'h80); send_bit(1'b1); send_bit(1'b0);
    reset = 1'b1;
    tick();
    check("t7_rst_busy", busy, 0);
    reset = 1'b0;
    repeat (20) tick();
    check("t7_no_end", n_end, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_rx_packet_ctrl.md
Name: usb_rx_packet_ctrl

Overview:
- Packet-level receive sequencer behind JKDecoder. It consumes the decoded bit stream (bit_out/bit_valid), frames it using bus_sop, checks SYNC and PID, and assembles payload bytes LSB-first.
- It signals end-of-packet and error status to the protocol layer.
- It converts the decoder's bus_reset level into a one-shot bus-reset event.

Parameters:
- IDLE_TIMEOUT, 8: clk36 cycles without bit_valid that end a packet (nominal bit spacing is 3 cycles).
- MAX_BYTES, 1025: maximum bytes after the PID (1023 data + 2 CRC); one more byte is an overflow.

Ports:
- clk36  in  1  system clock, 36 MHz.
- reset  in  1  synchronous, active-high reset.
- bit_in  in  1  decoded bit from JKDecoder bit_out.
- bit_valid  in  1  bit_in qualifier, one cycle per bit.
- bus_sop  in  1  start-of-packet pulse from the decoder.
- bus_reset  in  1  bus reset level from the decoder.
- pid_out  out  4  PID[3:0] of the current packet.
- pid_valid  out  1  one-cycle pulse: pid_out is valid and checked.
- byte_out  out  8  assembled payload byte.
- byte_valid  out  1  one-cycle pulse per payload byte.
- pkt_end  out  1  one-cycle pulse; exactly one per bus_sop.
- pkt_err  out  1  qualifies pkt_end; 1 = packet bad.
- err_code  out  2  0 SYNC mismatch, 1 PID check fail, 2 ALIGN/abort, 3 OVERFLOW; valid when pkt_err is 1.
- usb_reset_evt  out  1  one-cycle pulse on the rising edge of bus_reset.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, shift register 0, bit counter 0, byte counter 0, timeout counter 0.
- States: IDLE, SYNC, PID, DATA, DRAIN.
- Bit assembly: shift right, inserting bit_in at bit 7, so the first received bit lands in bit 0 after 8 bits.
- Bit counter: 3 bits; the 8th bit completes a byte.
- bit_valid in the same cycle as bus_sop is ignored.
- IDLE: on bus_sop, go to SYNC and clear the counters.
- SYNC: after 8 bits, the byte must equal 0x80.
  - Match: go to PID.
  - Mismatch: pkt_end=1, pkt_err=1, err_code=0, go to DRAIN.
- PID: after 8 bits, check byte[7:4] == ~byte[3:0].
  - Pass: pid_out=byte[3:0], pid_valid=1, go to DATA.
  - Fail: pkt_end, pkt_err, err_code=1, go to DRAIN.
- DATA: each completed byte drives byte_out and byte_valid=1, and increments the byte counter.
  - The byte that would make the count MAX_BYTES+1 is not emitted. Instead: pkt_end, pkt_err, err_code=3, go to DRAIN.
- Output latency: every output pulse is registered and appears 1 cycle after the bit_valid (or timeout) cycle that causes it.
- Timeout: a counter increments on every cycle without bit_valid in SYNC, PID, DATA and DRAIN, and clears on bit_valid. Reaching IDLE_TIMEOUT ends the packet:
  - DATA with bit counter 0: pkt_end, pkt_err=0; go to IDLE. A zero-byte packet (e.g. a handshake) is legal.
  - DATA with bit counter != 0, or in SYNC/PID: pkt_end, pkt_err, err_code=2; go to IDLE.
  - DRAIN: go to IDLE with no output; pkt_end was already issued.
- bus_sop outside IDLE: if not in DRAIN, issue pkt_end/pkt_err/err_code=2 for the old packet. In all cases, restart in SYNC with counters cleared.
- bus_reset:
  - Highest priority; register its previous value to detect the rising edge.
  - While bus_reset is high, the state is forced to IDLE and bit_valid/bus_sop are ignored.
  - On the first high cycle, if the state was SYNC/PID/DATA: pkt_end, pkt_err, err_code=2 in the same output cycle as usb_reset_evt.
- Reset asserted mid-packet: return to reset values next cycle, with no pkt_end.
- The byte counter saturates; it never wraps.

Test Plan:
- Bits spaced 3 cycles: sop, 0x80, 0xA5, 0x12, 0x34, then idle → pid_valid with pid_out=5; byte_valid 0x12 then 0x34; pkt_end with pkt_err=0 after 8 idle cycles; busy falls.
- SYNC sent as 0x81 → pkt_end, pkt_err=1, err_code=0 one cycle after the 8th bit; no pid_valid; remaining bits ignored until timeout.
- sop, 0x80, 0xD2 (ACK) → pid_out=2, zero bytes, clean pkt_end. Repeat with PID 0xD3 → err_code=1.
- sop, 0x80, 0xC3, 0x11, then 3 extra bits and idle → byte 0x11 emitted, then pkt_end with err_code=2.
- sop, 0x80, 0xC3, then 1026 bytes → 1025 byte_valid pulses; the 1026th byte gives err_code=3; no further byte_valid.
- bus_reset raised mid-DATA → usb_reset_evt pulses once with pkt_end, err_code=2; bus_reset held for 100 cycles produces no further pulses; a subsequent sop decodes normally.
